// File: rtl/accum_seq_ctrl.sv
// Accumulator sequencer for a MUL_SIZE x MUL_SIZE systolic MAC array.
// Each accepted command produces a skewed read stream and a matching write stream
// (delayed RD_LAT cycles). Both streams carry the row address, a lane mask and the
// add enable, and they cover the ramp-up, full and ramp-down phase of every K-tile.
// Ports:
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   start_i                      command valid, accepted when start_i & ready_o
//   u_dim_i, v_dim_i             reduction dim (tiles = U/MUL_SIZE), rows per tile
//   base_addr_i, bank_i          first accumulator row, bank select
//   acc_mode_i                   tile 0 also adds onto existing contents
//   ready_o, busy_o              idle / working
//   rd_en_o, rd_addr_o, rd_mask_o   accumulator read stream
//   wr_en_o, wr_addr_o, wr_mask_o   accumulator write stream
//   add_o, bank_o, done_o        add enable (write-aligned), latched bank, completion pulse
module accum_seq_ctrl #(
    parameter int unsigned MUL_SIZE = 32,
    parameter int unsigned DIM_W    = 8,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned FILL_LAT = 32,
    parameter int unsigned RD_LAT   = 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [DIM_W-1:0]    u_dim_i,
    input  logic [DIM_W-1:0]    v_dim_i,
    input  logic [ADDR_W-1:0]   base_addr_i,
    input  logic                bank_i,
    input  logic                acc_mode_i,
    output logic                ready_o,
    output logic                busy_o,
    output logic                rd_en_o,
    output logic [ADDR_W-1:0]   rd_addr_o,
    output logic [MUL_SIZE-1:0] rd_mask_o,
    output logic                wr_en_o,
    output logic [ADDR_W-1:0]   wr_addr_o,
    output logic [MUL_SIZE-1:0] wr_mask_o,
    output logic                add_o,
    output logic                bank_o,
    output logic                done_o
);

    localparam int unsigned LOG2M  = $clog2(MUL_SIZE);
    localparam int unsigned CNT_W  = DIM_W + LOG2M + 1;
    localparam int unsigned FILL_W = (FILL_LAT > 2) ? $clog2(FILL_LAT) : 1;
    localparam int unsigned DRN_W  = 3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              r_state, w_state_n;
    logic [FILL_W-1:0]   r_fill, w_fill_n;
    logic [CNT_W-1:0]    r_c, w_c_n;
    logic [DIM_W-1:0]    r_t, w_t_n;
    logic [DRN_W-1:0]    r_drn, w_drn_n;
    logic [DIM_W-1:0]    r_v, r_tiles;
    logic [ADDR_W-1:0]   r_base;
    logic                r_acc, r_bank;
    logic                r_ready, r_busy, r_done, r_rd_en;

    // Stream pipeline: index 0 is the current read-stream cycle, index RD_LAT the write stream
    logic                r_pv [RD_LAT+1];
    logic [ADDR_W-1:0]   r_pa [RD_LAT+1];
    logic [MUL_SIZE-1:0] r_pm [RD_LAT+1];
    logic                r_pd [RD_LAT+1];

    logic                w_accept, w_zero, w_done_n, w_ready_n;
    logic [DIM_W-1:0]    w_tiles_in, w_v_eff;
    logic [ADDR_W-1:0]   w_base_eff, w_addr_n;
    logic                w_acc_eff, w_sv, w_add_n;
    logic [CNT_W-1:0]    w_last_c;
    logic [MUL_SIZE-1:0] w_mask_n;

    assign w_accept   = start_i & r_ready;
    assign w_tiles_in = DIM_W'(u_dim_i >> LOG2M);
    assign w_zero     = (w_tiles_in == '0) | (v_dim_i == '0);
    // Live inputs are used only when a single-cycle fill starts streaming straight off accept
    assign w_v_eff    = w_accept ? v_dim_i     : r_v;
    assign w_base_eff = w_accept ? base_addr_i : r_base;
    assign w_acc_eff  = w_accept ? acc_mode_i  : r_acc;
    assign w_last_c   = CNT_W'(w_v_eff) + CNT_W'(MUL_SIZE - 2);

    // Next state and counters
    always_comb begin
        w_state_n = r_state;
        w_fill_n  = r_fill;
        w_c_n     = r_c;
        w_t_n     = r_t;
        w_drn_n   = r_drn;
        w_done_n  = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_n = S_IDLE;
                if (w_accept) begin
                    if (w_zero) begin
                        w_state_n = S_DONE;
                        w_done_n  = 1'b1;
                    end else if (FILL_LAT < 2) begin
                        w_state_n = S_STREAM;
                        w_c_n     = '0;
                        w_t_n     = '0;
                    end else begin
                        w_state_n = S_FILL;
                        w_fill_n  = '0;
                    end
                end
            end
            S_FILL: begin
                w_fill_n = r_fill + FILL_W'(1);
                if (r_fill == FILL_W'(FILL_LAT - 2)) begin
                    w_state_n = S_STREAM;
                    w_c_n     = '0;
                    w_t_n     = '0;
                end
            end
            S_STREAM: begin
                if (r_c == w_last_c) begin
                    w_c_n = '0;
                    if (r_t == r_tiles - DIM_W'(1)) begin
                        w_state_n = S_DRAIN;
                        w_drn_n   = '0;
                    end else begin
                        w_t_n = r_t + DIM_W'(1);
                    end
                end else begin
                    w_c_n = r_c + CNT_W'(1);
                end
            end
            S_DRAIN: begin
                w_drn_n = r_drn + DRN_W'(1);
                if (r_drn == DRN_W'(RD_LAT - 1)) begin
                    w_state_n = S_DONE;
                    w_done_n  = 1'b1;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // Read-stream values for the next cycle; lane j valid iff c-V < j <= c
    always_comb begin
        w_sv      = (w_state_n == S_STREAM);
        w_add_n   = w_sv & ((w_t_n != '0) | w_acc_eff);
        w_addr_n  = w_sv ? (w_base_eff + ADDR_W'(w_c_n)) : '0;
        w_ready_n = (w_state_n == S_IDLE) | (w_state_n == S_DONE);
        w_mask_n  = '0;
        for (int j = 0; j < MUL_SIZE; j++) begin
            w_mask_n[LOG2M'(MUL_SIZE - 1 - j)] = w_sv
                & (CNT_W'(j) <= w_c_n)
                & ((CNT_W'(j) + CNT_W'(w_v_eff)) > w_c_n);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_fill  <= '0;
            r_c     <= '0;
            r_t     <= '0;
            r_drn   <= '0;
            r_v     <= '0;
            r_tiles <= '0;
            r_base  <= '0;
            r_acc   <= 1'b0;
            r_bank  <= 1'b0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            for (int i = 0; i <= RD_LAT; i++) begin
                r_pv[i] <= 1'b0;
                r_pa[i] <= '0;
                r_pm[i] <= '0;
                r_pd[i] <= 1'b0;
            end
        end else begin
            r_state <= w_state_n;
            r_fill  <= w_fill_n;
            r_c     <= w_c_n;
            r_t     <= w_t_n;
            r_drn   <= w_drn_n;
            r_ready <= w_ready_n;
            r_busy  <= ~w_ready_n;
            r_done  <= w_done_n;
            r_rd_en <= w_add_n;
            if (w_accept) begin
                r_v     <= v_dim_i;
                r_tiles <= w_tiles_in;
                r_base  <= base_addr_i;
                r_acc   <= acc_mode_i;
                r_bank  <= bank_i;
            end
            r_pv[0] <= w_sv;
            r_pa[0] <= w_addr_n;
            r_pm[0] <= w_mask_n;
            r_pd[0] <= w_add_n;
            for (int i = 1; i <= RD_LAT; i++) begin
                r_pv[i] <= r_pv[i-1];
                r_pa[i] <= r_pa[i-1];
                r_pm[i] <= r_pm[i-1];
                r_pd[i] <= r_pd[i-1];
            end
        end
    end

    assign ready_o   = r_ready;
    assign busy_o    = r_busy;
    assign done_o    = r_done;
    assign bank_o    = r_bank;
    assign rd_en_o   = r_rd_en;
    assign rd_addr_o = r_pa[0];
    assign rd_mask_o = r_pm[0];
    assign wr_en_o   = r_pv[RD_LAT];
    assign wr_addr_o = r_pa[RD_LAT];
    assign wr_mask_o = r_pm[RD_LAT];
    assign add_o     = r_pd[RD_LAT];

endmodule
